// File: rtl/sistema_digital_rf.sv
`default_nettype none
// ============================================================================
// Module  : sistema_digital_rf
// Brief   : NREG x N register file with a 4-op ALU; executes Rd <- Rs1 op Rs2
//           through T and AC, one instruction per start handshake.
// Rev     : 1.0
// ============================================================================
module sistema_digital_rf #(
   parameter int  N    = 8,
   parameter int  NREG = 4,
   localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [AW-1:0] rd,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [N-1:0]  ld_data,
   input  logic [AW-1:0] rd_addr,
   output logic [N-1:0]  rd_data,
   output logic [N-1:0]  ac_q,
   output logic          busy,
   output logic          done,
   output logic          flag_z,
   output logic          flag_c
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_T = 3'd1,
      S_EXEC   = 3'd2,
      S_WRITE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q;
   logic [1:0]      op_q;
   logic [AW-1:0]   rd_q, rs1_q, rs2_q;
   logic [N-1:0]    t_q;
   logic [N-1:0]    regs_q [NREG];

   logic [N-1:0]    rs1_data, rs2_data;
   logic [N-1:0]    alu_res_d;
   logic            alu_c_d;
   logic [N:0]      sum_d;

   // Index decode by match: out-of-range addresses hit nothing, so they read 0.
   always_comb begin
      rd_data  = '0;
      rs1_data = '0;
      rs2_data = '0;
      for (int i = 0; i < NREG; i++) begin
         if (rd_addr == AW'(i)) rd_data  = regs_q[i];
         if (rs1_q   == AW'(i)) rs1_data = regs_q[i];
         if (rs2_q   == AW'(i)) rs2_data = regs_q[i];
      end
   end

   always_comb begin
      sum_d     = {1'b0, t_q} + {1'b0, rs2_data};
      alu_res_d = t_q;
      alu_c_d   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res_d = sum_d[N-1:0];
            alu_c_d   = sum_d[N];
         end
         OP_SUB: begin
            alu_res_d = t_q - rs2_data;
            alu_c_d   = (t_q < rs2_data);
         end
         OP_AND:  alu_res_d = t_q & rs2_data;
         default: alu_res_d = t_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         t_q     <= '0;
         ac_q    <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (ld_en) begin
                  for (int i = 0; i < NREG; i++)
                     if (ld_addr == AW'(i)) regs_q[i] <= ld_data;
               end
               if (start) begin
                  op_q    <= op;
                  rd_q    <= rd;
                  rs1_q   <= rs1;
                  rs2_q   <= rs2;
                  busy    <= 1'b1;
                  state_q <= S_LOAD_T;
               end
            end
            S_LOAD_T: begin
               t_q     <= rs1_data;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               ac_q    <= alu_res_d;
               flag_z  <= (alu_res_d == '0);
               flag_c  <= alu_c_d;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               for (int i = 0; i < NREG; i++)
                  if (rd_q == AW'(i)) regs_q[i] <= ac_q;
               done    <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               // A held start chains the next instruction with no idle gap.
               if (start) begin
                  op_q    <= op;
                  rd_q    <= rd;
                  rs1_q   <= rs1;
                  rs2_q   <= rs2;
                  state_q <= S_LOAD_T;
               end else begin
                  busy    <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sistema_digital_rf.sv
`default_nettype none
// ============================================================================
// Module  : tb_sistema_digital_rf
// Brief   : Scoreboard bench for sistema_digital_rf with a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_sistema_digital_rf;

   localparam int N    = 8;
   localparam int NREG = 4;
   localparam int AW   = 2;
   localparam int FULL = 1 << N;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = '0;
   logic [AW-1:0] rd = '0, rs1 = '0, rs2 = '0;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [N-1:0]  ld_data = '0;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] stim_addr = '0, mon_addr = '0;
   logic          mon_sel = 1'b0;
   logic [N-1:0]  rd_data, ac_q;
   logic          busy, done, flag_z, flag_c;

   assign rd_addr = mon_sel ? mon_addr : stim_addr;

   sistema_digital_rf #(.N(N), .NREG(NREG)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rd      (rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .ac_q    (ac_q),
      .busy    (busy),
      .done    (done),
      .flag_z  (flag_z),
      .flag_c  (flag_c)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rd;
      int res;
      int z;
      int c;
   } exp_t;

   exp_t sb[$];
   int   model [NREG];
   int   n_cmp = 0, n_err = 0, n_issued = 0, n_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference semantics from plain integer arithmetic.
   function automatic exp_t ref_op(input int o, input int a, input int b, input int d);
      exp_t e;
      e.rd = d;
      e.c  = 0;
      case (o)
         0: begin e.res = (a + b) % FULL;        e.c = ((a + b) >= FULL) ? 1 : 0; end
         1: begin e.res = (a - b + FULL) % FULL; e.c = (a < b) ? 1 : 0; end
         2: e.res = a & b;
         default: e.res = a;
      endcase
      e.z = (e.res == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic scramble();
      op  = 2'($urandom);
      rd  = AW'($urandom);
      rs1 = AW'($urandom);
      rs2 = AW'($urandom);
   endtask

   task automatic load(input int a, input int v);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(a); ld_data = N'(v);
      model[a] = v % FULL;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic check_reg(input int a, input int v);
      stim_addr = AW'(a);
      #1;
      chk($sformatf("reg_R%0d", a), rd_data, v);
   endtask

   task automatic issue(input int o, input int d, input int s1, input int s2,
                        input bit ld, input int la, input int lv);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = 2'(o); rd = AW'(d); rs1 = AW'(s1); rs2 = AW'(s2);
      if (ld) begin
         ld_en = 1'b1; ld_addr = AW'(la); ld_data = N'(lv);
         model[la] = lv % FULL;
      end
      e = ref_op(o, model[s1], model[s2], d);
      sb.push_back(e);
      model[d] = e.res;
      n_issued++;
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0; scramble();
      chk("busy_load_t", busy, 1);
      chk("done_load_t", done, 0);
      @(negedge clk); scramble();
      chk("done_exec", done, 0);
      @(negedge clk);
      chk("done_write", done, 0);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 1);
      @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
   endtask

   task automatic held3();
      exp_t e;
      int   o, d, s1, s2;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         o = $urandom_range(0, 3); d = $urandom_range(0, NREG-1);
         s1 = $urandom_range(0, NREG-1); s2 = $urandom_range(0, NREG-1);
         start = 1'b1; op = 2'(o); rd = AW'(d); rs1 = AW'(s1); rs2 = AW'(s2);
         e = ref_op(o, model[s1], model[s2], d);
         sb.push_back(e);
         model[d] = e.res;
         n_issued++;
         for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("held_busy", busy, 1);
            if (j < 4) begin
               scramble();
               chk("held_done_gap", done, 0);
            end else begin
               chk("held_done_pulse", done, 1);
            end
            // Load attempted while busy must be ignored.
            if (j == 2) begin
               ld_en = 1'b1; ld_addr = AW'($urandom); ld_data = N'($urandom);
            end
            if (j == 3) ld_en = 1'b0;
         end
      end
      start = 1'b0;
      @(negedge clk);
      chk("held_busy_end", busy, 0);
      chk("held_done_end", done, 0);
   endtask

   // Monitor: pops one expectation per done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               mon_addr = AW'(e.rd);
               mon_sel  = 1'b1;
               #1;
               chk("result_rd", rd_data, e.res);
               chk("result_ac", ac_q, e.res);
               chk("flag_z", flag_z, e.z);
               chk("flag_c", flag_c, e.c);
               mon_sel = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int o, d, s1, s2, la, lv;
      bit ld;
      for (int i = 0; i < NREG; i++) model[i] = 0;

      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ac", ac_q, 0);
      chk("rst_fz", flag_z, 0);
      chk("rst_fc", flag_c, 0);
      for (int i = 0; i < NREG; i++) check_reg(i, 0);
      @(negedge clk); reset = 1'b1;

      // Basic ADD / SUB
      load(0, 2); load(1, 4);
      issue(0, 2, 0, 1, 0, 0, 0);
      check_reg(2, 6);
      issue(1, 3, 0, 1, 0, 0, 0);
      check_reg(3, 8'hFE);
      issue(1, 3, 1, 1, 0, 0, 0);
      check_reg(3, 0);

      // Carry-out wrap, AND, MOV
      load(0, 8'hFF); load(1, 8'h01);
      issue(0, 0, 0, 1, 0, 0, 0);
      check_reg(0, 0);
      load(2, 8'hF0); load(3, 8'h3C);
      issue(2, 1, 2, 3, 0, 0, 0);
      check_reg(1, 8'h30);
      issue(3, 1, 2, 0, 0, 0, 0);
      check_reg(1, 8'hF0);

      // Aliasing and simultaneous load+start
      load(0, 8'h40);
      issue(0, 0, 0, 0, 0, 0, 0);
      check_reg(0, 8'h80);
      issue(0, 2, 1, 0, 1, 1, 7);
      check_reg(2, 8'h87);

      // Held start, mid-flight operand changes, load while busy
      held3();
      for (int i = 0; i < NREG; i++) check_reg(i, model[i]);

      // Randomised traffic
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 2) == 0) load($urandom_range(0, NREG-1), $urandom_range(0, FULL-1));
         o = $urandom_range(0, 3); d = $urandom_range(0, NREG-1);
         s1 = $urandom_range(0, NREG-1); s2 = $urandom_range(0, NREG-1);
         ld = ($urandom_range(0, 3) == 0);
         la = ($urandom_range(0, 1) == 0) ? s1 : $urandom_range(0, NREG-1);
         lv = $urandom_range(0, FULL-1);
         issue(o, d, s1, s2, ld, la, lv);
      end
      for (int i = 0; i < NREG; i++) check_reg(i, model[i]);

      // Asynchronous reset during EXEC aborts the instruction
      load(0, 2); load(1, 4);
      issue(0, 2, 0, 1, 0, 0, 0);
      issue(1, 3, 0, 1, 0, 0, 0);
      @(negedge clk);
      start = 1'b1; op = 2'(0); rd = AW'(1); rs1 = AW'(0); rs2 = AW'(1);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_ac", ac_q, 0);
      chk("arst_fz", flag_z, 0);
      chk("arst_fc", flag_c, 0);
      for (int i = 0; i < NREG; i++) begin
         model[i] = 0;
         check_reg(i, 0);
      end
      @(negedge clk); reset = 1'b1;
      load(0, 8'h11); load(1, 8'h22);
      issue(0, 2, 0, 1, 0, 0, 0);
      check_reg(2, 8'h33);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("done_count", n_done, n_issued);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
